// File: rtl/wb2axi4l_bridge_if.sv
// Bus bundle for the Wishbone-to-AXI4-Lite bridge.
// slave  : the bridge's view (Wishbone slave side, AXI4-Lite master side).
// master : the environment's view (Wishbone master plus AXI4-Lite responder).
interface wb2axi4l_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [31:0]           wb_dat_i;
  logic [3:0]            wb_sel_i;
  logic                  wb_we_i;
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;

  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [31:0]           m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/wb2axi4l_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transaction in flight.
// A request is captured in IDLE, issued on AXI, and answered with a single
// DONE cycle carrying ack (OKAY/EXOKAY) or err (SLVERR/DECERR).
module wb2axi4l_bridge #(
  parameter int ADDR_WIDTH = 32
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  wb2axi4l_bridge_if.slave     bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [31:0]           dat_q;
  logic [3:0]            sel_q;
  logic                  we_q;
  logic [1:0]            resp_q;
  logic [31:0]           rdat_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  // A channel counts as finished once its valid has been retired.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || bus.m_axi_awready;
  assign w_done  = !wvalid_q  || bus.m_axi_wready;

  // Transaction sequencer: capture, AXI handshakes and response capture.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      resp_q    <= 2'b00;
      rdat_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.wb_cyc_i && bus.wb_stb_i) begin
          adr_q <= bus.wb_adr_i;
          dat_q <= bus.wb_dat_i;
          sel_q <= bus.wb_sel_i;
          we_q  <= bus.wb_we_i;
          if (bus.wb_we_i) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= WRITE;
          end else begin
            arvalid_q <= 1'b1;
            state     <= READ;
          end
        end
        WRITE: begin
          // AW and W retire independently; B is only opened after both.
          if (awvalid_q && bus.m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.m_axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: if (bus.m_axi_bvalid) begin
          resp_q   <= bus.m_axi_bresp;
          bready_q <= 1'b0;
          state    <= DONE;
        end
        READ: if (bus.m_axi_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state     <= RDATA;
        end
        RDATA: if (bus.m_axi_rvalid) begin
          if (!we_q) rdat_q <= bus.m_axi_rdata;
          resp_q   <= bus.m_axi_rresp;
          rready_q <= 1'b0;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_axi_awaddr  = adr_q;
  assign bus.m_axi_araddr  = adr_q;
  assign bus.m_axi_wdata   = dat_q;
  assign bus.m_axi_wstrb   = sel_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign bus.wb_dat_o      = rdat_q;

  // DONE reports the captured response; a master that dropped cyc sees nothing.
  assign bus.wb_ack_o = (state == DONE) && bus.wb_cyc_i && !resp_q[1];
  assign bus.wb_err_o = (state == DONE) && bus.wb_cyc_i &&  resp_q[1];

endmodule

// File: doc/wb2axi4l_bridge.md
WB2AXI4L_BRIDGE -- requirements
Module: wb2axi4l_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of Wishbone and AXI4-Lite addresses; data width is fixed at 32.
REQ-002 SHALL have port wb_clk_i  input  1  single clock for all logic.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wb_adr_i  input  ADDR_WIDTH  Wishbone byte address.
REQ-005 SHALL have port wb_dat_i  input  32  Wishbone write data.
REQ-006 SHALL have port wb_sel_i  input  4  Wishbone byte selects.
REQ-007 SHALL have port wb_we_i  input  1  Wishbone write enable.
REQ-008 SHALL have port wb_cyc_i  input  1  Wishbone cycle.
REQ-009 SHALL have port wb_stb_i  input  1  Wishbone strobe.
REQ-010 SHALL have port wb_dat_o  output  32  Wishbone read data.
REQ-011 SHALL have port wb_ack_o  output  1  Wishbone acknowledge.
REQ-012 SHALL have port wb_err_o  output  1  Wishbone error.
REQ-013 SHALL have port m_axi_awaddr  output  ADDR_WIDTH  write address.
REQ-014 SHALL have port m_axi_awvalid  output  1  write address valid.
REQ-015 SHALL have port m_axi_awready  input  1  write address ready.
REQ-016 SHALL have port m_axi_wdata  output  32  write data.
REQ-017 SHALL have port m_axi_wstrb  output  4  write strobes.
REQ-018 SHALL have port m_axi_wvalid  output  1  write data valid.
REQ-019 SHALL have port m_axi_wready  input  1  write data ready.
REQ-020 SHALL have port m_axi_bresp  input  2  write response.
REQ-021 SHALL have port m_axi_bvalid  input  1  write response valid.
REQ-022 SHALL have port m_axi_bready  output  1  write response ready.
REQ-023 SHALL have port m_axi_araddr  output  ADDR_WIDTH  read address.
REQ-024 SHALL have port m_axi_arvalid  output  1  read address valid.
REQ-025 SHALL have port m_axi_arready  input  1  read address ready.
REQ-026 SHALL have port m_axi_rdata  input  32  read data.
REQ-027 SHALL have port m_axi_rresp  input  2  read response.
REQ-028 SHALL have port m_axi_rvalid  input  1  read data valid.
REQ-029 SHALL have port m_axi_rready  output  1  read data ready.

Function
REQ-030 SHALL implement a state machine with states IDLE, WRITE, WRESP, READ, RDATA, DONE and at most one transaction outstanding.
REQ-031 In IDLE, when wb_cyc_i&wb_stb_i are sampled high, the block SHALL register adr/dat/sel/we and go to WRITE (we=1) or READ (we=0); no request is sampled in any other state.
REQ-032 In WRITE, awvalid and wvalid SHALL both assert the cycle after capture; each deasserts independently after its own ready is sampled high; the transition to WRESP happens once both handshakes are done (same cycle or either order).
REQ-033 In WRESP, bready SHALL be 1; on bvalid the block SHALL capture bresp and go to DONE.
REQ-034 In READ, arvalid SHALL be held until arready, then go to RDATA with rready=1; on rvalid the block SHALL capture rdata into wb_dat_o and rresp, then go to DONE.
REQ-035 All AXI valids, once asserted, SHALL stay high with awaddr/wdata/wstrb/araddr stable until the handshake; awaddr=araddr=captured address unmodified; wstrb=captured sel (sel=0 is still issued).
REQ-036 DONE SHALL last one cycle: wb_ack_o=1 if resp is 2'b00 or 2'b01, else wb_err_o=1 (never both); the block then returns to IDLE.
REQ-037 Minimum latency with ready/valid responders always high SHALL be ack/err 3 cycles after the request is sampled.
REQ-038 wb_dat_o SHALL be registered, updated only on read completion, and held otherwise.
REQ-039 If wb_cyc_i is low in DONE (master abort), the AXI transaction SHALL still complete and ack/err SHALL be suppressed.

Reset
REQ-040 While wb_rst_i=1 (asynchronous assert), the block SHALL set state=IDLE, all AXI valid/ready outputs=0, wb_ack_o=0, wb_err_o=0, and wb_dat_o and all captured registers=0; release SHALL take effect on the next wb_clk_i edge, and reset mid-transaction SHALL abandon the transaction.

Verification
REQ-041 Write adr=0x10, dat=0xDEADBEEF, sel=0xF, all readies high, bresp=00 -> awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, wb_ack_o pulse 3 cycles after sampling.
REQ-042 Read adr=0x20, arready delayed 4 cycles, rdata=0x12345678, rresp=00 -> arvalid held 5 cycles, wb_dat_o=0x12345678 with ack.
REQ-043 Write with wready 3 cycles before awready -> wvalid drops after its own handshake, bready only after both, single ack.
REQ-044 Read with rresp=10 and write with bresp=11 -> wb_err_o=1, wb_ack_o=0 for each.
REQ-045 Reset asserted in WRESP, then a new read -> outputs 0 immediately, new read completes normally with no spurious ack.
